// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and decodes immediate type and ALU op.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src
);

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_FUNC = 2'd2
  } aluop_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e state_q, state_d;
  aluop_e aluop;
  logic   pc_update;
  logic   branch;

  // State register; reset forces an immediate return to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode; strobes are suppressed while in reset.
  always_comb begin
    state_d    = S_FETCH;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    aluop      = OP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OpLoad, OpStore: state_d = S_MEMADR;
          OpRType:         state_d = S_EXECR;
          OpIType:         state_d = S_EXECI;
          OpJal:           state_d = S_JAL;
          OpBranch:        state_d = S_BEQ;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        aluop     = OP_FUNC;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = OP_FUNC;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        aluop     = OP_SUB;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
    end
    pc_write = pc_update | (branch & zero);
  end

  // ALU operation decode; only sub for R-type sets funct7b5 meaning.
  always_comb begin
    alu_control = 3'b000;
    case (aluop)
      OP_SUB:  alu_control = 3'b001;
      OP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate format select, straight from the opcode in every state.
  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      OpStore:  imm_src = 2'b01;
      OpBranch: imm_src = 2'b10;
      OpJal:    imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the packed output vector to hand tables.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] imm_src;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcw, adr, mw, irw, rw, result_src, a, b, alu_control, imm_src}
  logic [15:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control, imm_src};

  function automatic logic [15:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [2:0] alu, input logic [1:0] imm);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm};
  endfunction

  // Hand-written expected outputs for each step.
  function automatic logic [15:0] e_fetch(input logic [1:0] imm);
    return v(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_reset(input logic [1:0] imm);
    return v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_decode(input logic [1:0] imm);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_memadr(input logic [1:0] imm);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_memread(input logic [1:0] imm);
    return v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_memwb(input logic [1:0] imm);
    return v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_memwrite(input logic [1:0] imm);
    return v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_execr(input logic [2:0] alu);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00);
  endfunction
  function automatic logic [15:0] e_execi(input logic [2:0] alu);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 2'b00);
  endfunction
  function automatic logic [15:0] e_aluwb(input logic [1:0] imm);
    return v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm);
  endfunction
  function automatic logic [15:0] e_jal();
    return v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11);
  endfunction
  function automatic logic [15:0] e_beq(input logic z);
    return v(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Compare this cycle's outputs, then advance one clock edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    check(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_outs", outs, e_reset(2'b00));
    @(negedge clk);
    rst = 1'b0;
    #1;

    // lw: 5 cycles
    cyc("lw_fetch",   e_fetch(2'b00));
    cyc("lw_decode",  e_decode(2'b00));
    cyc("lw_memadr",  e_memadr(2'b00));
    cyc("lw_memread", e_memread(2'b00));
    cyc("lw_memwb",   e_memwb(2'b00));

    // sw: 4 cycles
    set_in(7'b0100011, 3'b010, 1'b0, 1'b1);
    cyc("sw_fetch",    e_fetch(2'b01));
    cyc("sw_decode",   e_decode(2'b01));
    cyc("sw_memadr",   e_memadr(2'b01));
    cyc("sw_memwrite", e_memwrite(2'b01));

    // R-type sub, zero held high to expose any stray branch path
    set_in(7'b0110011, 3'b000, 1'b1, 1'b1);
    cyc("sub_fetch",  e_fetch(2'b00));
    cyc("sub_decode", e_decode(2'b00));
    cyc("sub_execr",  e_execr(3'b001));
    cyc("sub_aluwb",  e_aluwb(2'b00));

    // R-type add
    set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
    cyc("add_fetch",  e_fetch(2'b00));
    cyc("add_decode", e_decode(2'b00));
    cyc("add_execr",  e_execr(3'b000));
    cyc("add_aluwb",  e_aluwb(2'b00));

    // addi with funct7b5=1 must still add
    set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
    cyc("addi_fetch",  e_fetch(2'b00));
    cyc("addi_decode", e_decode(2'b00));
    cyc("addi_execi",  e_execi(3'b000));
    cyc("addi_aluwb",  e_aluwb(2'b00));

    // R-type slt
    set_in(7'b0110011, 3'b010, 1'b0, 1'b0);
    cyc("slt_fetch",  e_fetch(2'b00));
    cyc("slt_decode", e_decode(2'b00));
    cyc("slt_execr",  e_execr(3'b101));
    cyc("slt_aluwb",  e_aluwb(2'b00));

    // I-type ori
    set_in(7'b0010011, 3'b110, 1'b0, 1'b0);
    cyc("ori_fetch",  e_fetch(2'b00));
    cyc("ori_decode", e_decode(2'b00));
    cyc("ori_execi",  e_execi(3'b011));
    cyc("ori_aluwb",  e_aluwb(2'b00));

    // R-type and
    set_in(7'b0110011, 3'b111, 1'b0, 1'b0);
    cyc("and_fetch",  e_fetch(2'b00));
    cyc("and_decode", e_decode(2'b00));
    cyc("and_execr",  e_execr(3'b010));
    cyc("and_aluwb",  e_aluwb(2'b00));

    // beq taken: zero only raised once BEQ is reached
    set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
    cyc("beqt_fetch",  e_fetch(2'b10));
    cyc("beqt_decode", e_decode(2'b10));
    set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc("beqt_beq",    e_beq(1'b1));

    // beq not taken
    set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
    cyc("beqn_fetch",  e_fetch(2'b10));
    cyc("beqn_decode", e_decode(2'b10));
    cyc("beqn_beq",    e_beq(1'b0));

    // jal: 4 cycles
    set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc("jal_fetch",  e_fetch(2'b11));
    cyc("jal_decode", e_decode(2'b11));
    cyc("jal_jal",    e_jal());
    cyc("jal_aluwb",  e_aluwb(2'b11));

    // illegal opcode: back to FETCH after decode
    set_in(7'b1111111, 3'b000, 1'b0, 1'b1);
    cyc("ill_fetch",  e_fetch(2'b00));
    cyc("ill_decode", e_decode(2'b00));

    // sw interrupted by reset in MEMWRITE
    set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc("swr_fetch",  e_fetch(2'b01));
    cyc("swr_decode", e_decode(2'b01));
    cyc("swr_memadr", e_memadr(2'b01));
    check("swr_memwrite", outs, e_memwrite(2'b01));
    #2;
    rst = 1'b1;
    #1;
    check("swr_in_reset", outs, e_reset(2'b01));
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc("swr_post_fetch",  e_fetch(2'b01));
    cyc("swr_post_decode", e_decode(2'b01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
